// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: datapath width, PC increment, NOP encoding,
// the {pc, insn} buffer entry layout and the PC alignment helper.
package rv_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, insn} pairs with push, pop and flush.
// The head output reads as zero while the buffer is empty.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int W = 2 * XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && !empty_o && !flush_i;
        do_push  = push_i && !flush_i && (!full_o || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: sequential PC, two-entry output buffer, redirect handling.
// Optional FETCH_MISALIGN_TRAP_EN adds a sticky misalign_fault on unaligned redirects.
module insn_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] insn_addr,
    input  logic [XLEN-1:0] insn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_insn,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_target;
    logic            fetch_en;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    assign redirect_target = redirect_pc;
    assign fetch_en        = !fault_q;
    assign misalign_fault  = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic unused_redirect_lsb;

    assign redirect_target     = pc_align(redirect_pc);
    assign fetch_en            = 1'b1;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    assign insn_addr = pc_q;
    assign wr_entry  = '{pc: pc_q, insn: insn};

    // Redirect wins over everything: the buffer is flushed and this cycle's fetch is dropped.
    always_comb begin
        pc_d = pc_q;
        pop  = out_valid && out_ready && !redirect_valid;
        push = !redirect_valid && fetch_en && (!fifo_full || pop);
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .W ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head.pc;
    assign out_insn  = head.insn;

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: a per-cycle vector table, a backpressure
// sequence drained through a scoreboard queue, and an asynchronous reset check.
module tb_insn_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insn_addr;
    logic [31:0] insn;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        fault_obs;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word holds its own word index.
    assign insn = {22'b0, insn_addr[11:2]};

    insn_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .insn_addr      (insn_addr),
        .insn           (insn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (fault_obs)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fault_obs = 1'b0;
`endif

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einsn;
        logic [31:0] eaddr;
        logic        efault;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    logic [63:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // rdy, redir, rpc, exp_valid, exp_pc, exp_insn, exp_addr, exp_fault
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,   32'h4,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h1,   32'h8,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h2,   32'hC,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h2,   32'h10,       1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h2,   32'h10,       1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h2,   32'h10,       1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,   32'h40,       1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       32'h10,  32'h44,       1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44,       32'h11,  32'h48,       1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       32'h0,   32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h3FF, 32'h0,       1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,   32'h4,        1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h1,   32'h8,        1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[13] = '{1'b1, 1'b1, 32'h42,       1'b0, 32'h0,        32'h0,   32'h42,       1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,   32'h42,       1'b1};
`else
        vecs[13] = '{1'b1, 1'b1, 32'h103,      1'b0, 32'h0,        32'h0,   32'h100,      1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      32'h40,  32'h104,      1'b0};
`endif
        vecs[15] = '{1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h0,   32'h80,       1'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h80,       32'h20,  32'h84,       1'b0};

        // Reset state
        tick();
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_insn", out_insn, 32'h0);
        check("reset insn_addr", insn_addr, 32'h0);
        tick();
        rst = 1'b0;

        // Per-cycle vector table
        for (int i = 0; i < NVEC; i++) begin
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            tick();
            redirect_valid = 1'b0;
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) begin
                check($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
                check($sformatf("v%0d out_insn", i), out_insn, vecs[i].einsn);
            end
            check($sformatf("v%0d insn_addr", i), insn_addr, vecs[i].eaddr);
`ifdef FETCH_MISALIGN_TRAP_EN
            check($sformatf("v%0d misalign_fault", i), {31'b0, fault_obs}, {31'b0, vecs[i].efault});
`endif
        end

        // Backpressure: hold out_ready low for 5 cycles, then drain via scoreboard
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'h1);
            check($sformatf("stall%0d out_pc", c), out_pc, 32'h0);
        end
        check("stall insn_addr", insn_addr, 32'h8);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back({32'(k * 4), 32'(k)});
        end
        for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
            if (out_valid) begin
                logic [63:0] exp_e;
                exp_e = sb_q.pop_front();
                check("drain out_pc", out_pc, exp_e[63:32]);
                check("drain out_insn", out_insn, exp_e[31:0]);
            end
            tick();
        end
        if (sb_q.size() != 0) begin
            check("drain timeout remaining", 32'(sb_q.size()), 32'h0);
        end

        // Asynchronous reset mid-stream
        tick();
        check("pre-rst out_valid", {31'b0, out_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'h0);
        check("async rst insn_addr", insn_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post-rst out_valid", {31'b0, out_valid}, 32'h1);
        check("post-rst out_pc", out_pc, 32'h0);
        tick();
        check("post-rst out_pc 2", out_pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
